// File: rtl/edge_gen_pkg.sv
// edge_gen_pkg: shared types and defaults for the edge pattern generator
package edge_gen_pkg;
    localparam int CNT_W = 8;
    typedef enum logic {IDLE, HOLD} gen_state_t;
    typedef struct packed {
        logic             level;
        logic [CNT_W-1:0] len;
    } edge_cmd_t;
endpackage

// File: rtl/edge_pattern_gen_if.sv
// edge_pattern_gen_if: valid/ready command port carrying {level, hold length}
interface edge_pattern_gen_if #(parameter int CNT_W = 8);
    logic             Cmd_Valid;
    logic             Cmd_Ready;
    logic             Cmd_Level;
    logic [CNT_W-1:0] Cmd_Len;
    modport master (output Cmd_Valid, Cmd_Level, Cmd_Len, input Cmd_Ready);
    modport slave (input Cmd_Valid, Cmd_Level, Cmd_Len, output Cmd_Ready);
endinterface

// File: rtl/edge_cmd_fifo.sv
// edge_cmd_fifo: show-ahead synchronous FIFO; pointers carry an extra wrap bit
module edge_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    always_comb begin
        wr_d = push ? wr_q + (AW+1)'(1) : wr_q;
        rd_d = pop ? rd_q + (AW+1)'(1) : rd_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= wdata;
    end
    assign empty = wr_q == rd_q;
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign rdata = mem_q[rd_q[AW-1:0]];
endmodule

// File: rtl/edge_pattern_gen.sv
// edge_pattern_gen: plays queued {level, length} commands onto A with edge strobes
module edge_pattern_gen #(
    parameter int   CNT_W      = 8,
    parameter int   DEPTH      = 4,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic              Clk,
    input  logic              Rst,
    edge_pattern_gen_if.slave cmd,
    output logic              A,
    output logic              Rise_Strobe,
    output logic              Fall_Strobe,
    output logic              Busy,
    output logic              Done
);
    import edge_gen_pkg::*;
    gen_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, head_len;
    logic             a_q, a_d, rise_q, rise_d, fall_q, fall_d, done_q, done_d;
    logic             push, pop, full, empty, head_level;
    assign cmd.Cmd_Ready = !full;
    assign push          = cmd.Cmd_Valid && !full;
    edge_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(CNT_W + 1)) u_fifo (
        .clk   (Clk),
        .rst   (Rst),
        .push  (push),
        .pop   (pop),
        .wdata ({cmd.Cmd_Level, cmd.Cmd_Len}),
        .rdata ({head_level, head_len}),
        .full  (full),
        .empty (empty)
    );
    // cnt holds the remaining cycles after the current one, so the next
    // command loads on the edge that ends the final hold cycle
    always_comb begin
        pop     = !empty && (state_q == IDLE || cnt_q == '0);
        state_d = pop ? HOLD : (cnt_q == '0 ? IDLE : state_q);
        cnt_d   = pop ? (head_len == '0 ? '0 : head_len - CNT_W'(1))
                      : (cnt_q == '0 ? cnt_q : cnt_q - CNT_W'(1));
        a_d     = pop ? head_level : a_q;
        rise_d  = pop && head_level && !a_q;
        fall_d  = pop && !head_level && a_q;
        done_d  = !pop && state_q == HOLD && cnt_q == '0;
    end
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= IDLE_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            done_q  <= done_d;
        end
    end
    assign A           = a_q;
    assign Rise_Strobe = rise_q;
    assign Fall_Strobe = fall_q;
    assign Done        = done_q;
    assign Busy        = state_q == HOLD || !empty;
endmodule

// File: tb/tb_edge_pattern_gen.sv
// tb_edge_pattern_gen: timeline-based reference model of the generator,
// checked every cycle, plus literal expectations for the directed scenarios
module tb_edge_pattern_gen;
    localparam int NC       = 8192;
    localparam int DEPTH    = 4;
    localparam bit IDLE_LVL = 1'b1;
    logic Clk = 1'b0;
    logic Rst = 1'b1;
    logic A, rise, fall, busy, done;
    edge_pattern_gen_if #(.CNT_W(8)) cmd_if ();
    edge_pattern_gen #(.CNT_W(8), .DEPTH(DEPTH), .IDLE_LEVEL(IDLE_LVL)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .cmd         (cmd_if),
        .A           (A),
        .Rise_Strobe (rise),
        .Fall_Strobe (fall),
        .Busy        (busy),
        .Done        (done)
    );
    always #5 Clk = ~Clk;
    // expected values after edge t, and the recorded DUT values after edge t
    bit ea[NC], er[NC], ef[NC], ed[NC], eb[NC];
    int eo[NC];
    bit da[NC], dr[NC], df[NC], dd[NC], db[NC], dy[NC];
    int cyc = 0, next_free = 0, last_start = 0, last_acc = 0, last_reset = 0;
    int checks = 0, errors = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask
    task automatic m_reset(input int r);
        for (int t = r; t < NC; t++) begin
            ea[t] = IDLE_LVL; er[t] = 0; ef[t] = 0; ed[t] = 0; eb[t] = 0; eo[t] = 0;
        end
        next_free  = 0;
        last_reset = r;
    endtask
    // a command accepted at edge k starts at the later of k+1 and the end of
    // everything queued before it, and occupies A for max(len,1) cycles
    task automatic m_push(input int k, input bit l, input int n);
        int len, s;
        len = (n == 0) ? 1 : n;
        s = (next_free > k + 1) ? next_free : k + 1;
        er[s] = l && !ea[s-1];
        ef[s] = !l && ea[s-1];
        ed[s] = 0;
        for (int t = s; t < NC; t++) ea[t] = l;
        for (int t = k; t < s + len; t++) eb[t] = 1;
        for (int t = k; t < s; t++) eo[t]++;
        next_free = s + len;
        ed[next_free] = 1;
        last_start = s;
        last_acc = k;
    endtask
    initial forever begin
        @(posedge Clk);
        cyc++;
        if (cyc >= NC - 300) begin
            $display("FAIL cycle_budget exceeded at cycle %0d", cyc);
            $fatal(1);
        end
        if (Rst) m_reset(cyc);
        else if (cmd_if.Cmd_Valid && eo[cyc-1] < DEPTH) m_push(cyc, cmd_if.Cmd_Level, int'(cmd_if.Cmd_Len));
    end
    initial forever begin
        @(negedge Clk);
        if (cyc >= 1) begin
            da[cyc] = A; dr[cyc] = rise; df[cyc] = fall; dd[cyc] = done; db[cyc] = busy; dy[cyc] = cmd_if.Cmd_Ready;
            chk("A", A, ea[cyc]);
            chk("rise", rise, er[cyc]);
            chk("fall", fall, ef[cyc]);
            chk("done", done, ed[cyc]);
            chk("busy", busy, eb[cyc]);
            chk("ready", cmd_if.Cmd_Ready, eo[cyc] < DEPTH);
        end
    end
    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end
    function automatic int sum_a(input int a, input int b);
        int n = 0;
        for (int t = a; t <= b; t++) n += da[t];
        return n;
    endfunction
    function automatic int sum_edges(input int a, input int b, input bit want_rise);
        int n = 0;
        for (int t = a; t <= b; t++) n += want_rise ? dr[t] : df[t];
        return n;
    endfunction
    task automatic push(input bit l, input int n);
        int w = 0;
        cmd_if.Cmd_Valid = 1'b1;
        cmd_if.Cmd_Level = l;
        cmd_if.Cmd_Len   = 8'(n);
        while (eo[cyc] >= DEPTH && w < 3000) begin
            @(negedge Clk);
            w++;
        end
        if (w >= 3000) chk("push_timeout", w, 0);
        @(negedge Clk);
        cmd_if.Cmd_Valid = 1'b0;
    endtask
    task automatic wait_idle();
        int w = 0;
        while ((cyc < next_free || eo[cyc] != 0) && w < 3000) begin
            @(negedge Clk);
            w++;
        end
        if (w >= 3000) chk("idle_timeout", w, 0);
        repeat (3) @(negedge Clk);
    endtask
    task automatic do_reset();
        cmd_if.Cmd_Valid = 1'b0;
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
    endtask
    initial begin
        int s, k, r;
        logic [8:0] w, we;
        cmd_if.Cmd_Valid = 1'b0;
        cmd_if.Cmd_Level = 1'b0;
        cmd_if.Cmd_Len   = '0;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        repeat (4) @(negedge Clk);
        chk("rst_a", da[2], 1);
        chk("rst_ready", dy[2], 1);
        chk("rst_busy", db[2], 0);
        chk("rst_strobes", sum_edges(1, 5, 1) + sum_edges(1, 5, 0), 0);
        chk("rst_a_after", da[5], 1);
        // single command
        push(0, 1);
        wait_idle();
        push(1, 3);
        k = last_acc;
        s = last_start;
        wait_idle();
        chk("single_latency", s - k, 1);
        chk("single_pre", da[s-1], 0);
        chk("single_high", sum_a(s, s + 2), 3);
        chk("single_rise", dr[s], 1);
        chk("single_edges", sum_edges(s, s + 4, 1) + sum_edges(s, s + 4, 0), 1);
        chk("single_done", dd[s+3], 1);
        chk("single_done_once", dd[s+2] + dd[s+4], 0);
        chk("single_hold_a", da[s+3], 1);
        // back-to-back sequence
        push(0, 1);
        wait_idle();
        push(1, 2);
        s = last_start;
        push(0, 1);
        push(1, 4);
        push(1, 2);
        wait_idle();
        for (int i = 0; i < 9; i++) begin
            w[8-i]  = da[s+i];
            we[8-i] = ea[s+i];
        end
        chk("seq_wave", w, 9'b110111111);
        chk("seq_model_wave", we, 9'b110111111);
        chk("seq_rises", sum_edges(s, s + 9, 1), 2);
        chk("seq_falls", sum_edges(s, s + 9, 0), 1);
        chk("seq_done", dd[s+9], 1);
        chk("seq_busy_last", db[s+8], 1);
        chk("seq_busy_end", db[s+9], 0);
        // zero length
        push(0, 1);
        wait_idle();
        push(1, 0);
        s = last_start;
        push(0, 0);
        wait_idle();
        chk("zero_rise", dr[s], 1);
        chk("zero_fall", df[s+1], 1);
        chk("zero_wave", {da[s], da[s+1]}, 2'b10);
        chk("zero_done", dd[s+2], 1);
        // full FIFO with Cmd_Valid held high
        push(0, 200);
        k = last_acc;
        s = last_start;
        repeat (5) push(1, 1);
        wait_idle();
        chk("full_ready_3", dy[k+3], 1);
        chk("full_ready_4", dy[k+4], 0);
        chk("full_ready_wait", dy[s+199], 0);
        chk("full_ready_freed", dy[s+200], 1);
        chk("full_low_end", da[s+199], 0);
        chk("full_high", sum_a(s + 200, s + 204), 5);
        chk("full_done", dd[s+205], 1);
        chk("full_no_early_done", dd[s+204], 0);
        chk("full_rises", sum_edges(s, s + 206, 1), 1);
        // mid-operation reset during a long hold with two queued
        push(1, 50);
        push(0, 3);
        push(1, 3);
        repeat (10) @(negedge Clk);
        do_reset();
        r = last_reset;
        repeat (5) @(negedge Clk);
        chk("mrst_a", da[r], 1);
        chk("mrst_busy", db[r], 0);
        chk("mrst_ready", dy[r], 1);
        chk("mrst_strobes", sum_edges(r, r + 4, 1) + sum_edges(r, r + 4, 0), 0);
        chk("mrst_idle", db[r+1] + db[r+2] + db[r+3] + db[r+4], 0);
        push(1, 2);
        k = last_acc;
        s = last_start;
        wait_idle();
        chk("mrst_latency", s - k, 1);
        chk("mrst_high", sum_a(s, s + 1), 2);
        chk("mrst_done", dd[s+2], 1);
        // reset while low: A returns to the idle level silently
        push(0, 50);
        repeat (5) @(negedge Clk);
        do_reset();
        r = last_reset;
        @(negedge Clk);
        chk("lrst_pre", da[r-1], 0);
        chk("lrst_a", da[r], 1);
        chk("lrst_rise", dr[r], 0);
        // randomized traffic with occasional resets
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 30) == 0) do_reset();
            repeat ($urandom_range(0, 2)) @(negedge Clk);
            push(1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 4));
        end
        wait_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
